// File: rtl/counter_pkg.sv
// Shared state encoding and default widths for the counter sweep controller.
package counter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DW    = 4;
    localparam int DEF_NW    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } sweep_state_e;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Control bus between the sweep sequencer (master) and the up/down counter (slave).
interface counter_sweep_ctrl_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DW    = DEF_DW
);

    logic             preload;
    logic             up_dn;
    logic [DW-1:0]    delta;
    logic [WIDTH-1:0] pl_data;
    logic [WIDTH-1:0] qout;

    modport master (
        output preload,
        output up_dn,
        output delta,
        output pl_data,
        input  qout
    );

    modport slave (
        input  preload,
        input  up_dn,
        input  delta,
        input  pl_data,
        output qout
    );

endinterface

// File: rtl/sweep_limit_cmp.sv
// Limit detection for the sweep; one extra bit keeps qout+step from wrapping near the top of the range.
module sweep_limit_cmp
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DW    = DEF_DW
) (
    input  logic [WIDTH-1:0] qout,
    input  logic [DW-1:0]    step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             top_hit,
    output logic             bot_hit
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] up_next;
    logic [WIDTH:0] lo_plus;

    assign step_ext = (WIDTH+1)'(step);
    assign up_next  = {1'b0, qout} + step_ext;
    assign lo_plus  = {1'b0, lo} + step_ext;

    assign top_hit = up_next > {1'b0, hi};
    assign bot_hit = {1'b0, qout} < lo_plus;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that drives an external up/down counter through N triangle sweeps between latched limits.
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DW    = DEF_DW,
    parameter int NW    = DEF_NW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      lo_lim,
    input  logic [WIDTH-1:0]      hi_lim,
    input  logic [DW-1:0]         step,
    input  logic [NW-1:0]         n_sweeps,
    counter_sweep_ctrl_if.master  cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [NW-1:0]         sweep_cnt
);

    sweep_state_e     state;
    sweep_state_e     state_nx;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [DW-1:0]    step_r;
    logic [NW-1:0]    n_r;
    logic [NW-1:0]    cnt_inc;
    logic             top_hit;
    logic             bot_hit;
    logic             cfg_bad;
    logic             accept;
    logic             last_sweep;
    logic             preload_c;
    logic             up_dn_c;
    logic [DW-1:0]    delta_c;

    sweep_limit_cmp #(
        .WIDTH (WIDTH),
        .DW    (DW)
    ) u_cmp (
        .qout    (cnt.qout),
        .step    (step_r),
        .lo      (lo_r),
        .hi      (hi_r),
        .top_hit (top_hit),
        .bot_hit (bot_hit)
    );

    // The span check also rejects ranges too narrow to take a single step.
    assign cfg_bad    = (step == '0) || (lo_lim > hi_lim) ||
                        ((hi_lim - lo_lim) < WIDTH'(step));
    assign accept     = (state == IDLE) && start && !abort && !cfg_bad;
    assign cnt_inc    = sweep_cnt + NW'(1);
    assign last_sweep = (n_r != '0) && (cnt_inc == n_r);

    always_comb begin
        state_nx  = state;
        preload_c = 1'b0;
        up_dn_c   = 1'b0;
        delta_c   = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nx = LOAD;
            end
            LOAD: begin
                preload_c = 1'b1;
                state_nx  = UP;
            end
            UP: begin
                delta_c = step_r;
                up_dn_c = !top_hit;
                if (top_hit)
                    state_nx = DOWN;
            end
            DOWN: begin
                delta_c = step_r;
                if (bot_hit) begin
                    if (last_sweep) begin
                        delta_c  = '0;
                        state_nx = DONE;
                    end else begin
                        up_dn_c  = 1'b1;
                        state_nx = UP;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort && (state != IDLE))
            state_nx = IDLE;
    end

    // A trough reached in the same cycle as abort is not counted as a completed sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            step_r    <= '0;
            n_r       <= '0;
            sweep_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= (state == IDLE) && start && !abort && cfg_bad;
            if (accept) begin
                lo_r      <= lo_lim;
                hi_r      <= hi_lim;
                step_r    <= step;
                n_r       <= n_sweeps;
                sweep_cnt <= '0;
            end else if ((state == DOWN) && bot_hit && !abort) begin
                sweep_cnt <= cnt_inc;
            end
        end
    end

    assign cnt.preload = preload_c;
    assign cnt.up_dn   = up_dn_c;
    assign cnt.delta   = delta_c;
    assign cnt.pl_data = lo_r;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule
